// File: rtl/axil_arb_pkg.sv
// Shared types for the two-requester AXI4-lite arbiter.
package axil_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2
  } arb_state_t;

  typedef logic req_idx_t;

endpackage

// File: rtl/axil_arb_rr.sv
// Two-way round-robin pick: on a tie the requester not granted last time wins.
module axil_arb_rr
  import axil_arb_pkg::*;
(
  input  logic [1:0] req,
  input  req_idx_t   last_gnt,
  output logic       gnt_valid,
  output req_idx_t   gnt_idx
);

  always_comb begin
    gnt_valid = |req;
    if (&req) gnt_idx = ~last_gnt;
    else      gnt_idx = req[1];
  end

endmodule

// File: rtl/axil_arb2.sv
// AXI4-lite 2:1 arbiter: two requesters share one master port, one transaction at a time.
module axil_arb2
  import axil_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                s0_axi_awvalid,
  output logic                s0_axi_awready,
  input  logic [ADDR_W-1:0]   s0_axi_awaddr,
  input  logic [2:0]          s0_axi_awprot,
  input  logic                s0_axi_wvalid,
  output logic                s0_axi_wready,
  input  logic [DATA_W-1:0]   s0_axi_wdata,
  input  logic [DATA_W/8-1:0] s0_axi_wstrb,
  output logic                s0_axi_bvalid,
  input  logic                s0_axi_bready,
  input  logic                s0_axi_arvalid,
  output logic                s0_axi_arready,
  input  logic [ADDR_W-1:0]   s0_axi_araddr,
  input  logic [2:0]          s0_axi_arprot,
  output logic                s0_axi_rvalid,
  input  logic                s0_axi_rready,
  output logic [DATA_W-1:0]   s0_axi_rdata,
  input  logic                s1_axi_awvalid,
  output logic                s1_axi_awready,
  input  logic [ADDR_W-1:0]   s1_axi_awaddr,
  input  logic [2:0]          s1_axi_awprot,
  input  logic                s1_axi_wvalid,
  output logic                s1_axi_wready,
  input  logic [DATA_W-1:0]   s1_axi_wdata,
  input  logic [DATA_W/8-1:0] s1_axi_wstrb,
  output logic                s1_axi_bvalid,
  input  logic                s1_axi_bready,
  input  logic                s1_axi_arvalid,
  output logic                s1_axi_arready,
  input  logic [ADDR_W-1:0]   s1_axi_araddr,
  input  logic [2:0]          s1_axi_arprot,
  output logic                s1_axi_rvalid,
  input  logic                s1_axi_rready,
  output logic [DATA_W-1:0]   s1_axi_rdata,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic [2:0]          m_axi_awprot,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  output logic [ADDR_W-1:0]   m_axi_araddr,
  output logic [2:0]          m_axi_arprot,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready,
  input  logic [DATA_W-1:0]   m_axi_rdata
);

  arb_state_t state;
  req_idx_t   owner, last_gnt, gnt_idx;
  logic       gnt_valid, aw_done, w_done, ar_done;
  logic [1:0] wr_req, rd_req;
  logic       in_wr, in_rd, own0, own1;
  logic       sel_awvalid, sel_wvalid, sel_bready, sel_arvalid, sel_rready;

  assign wr_req = {s1_axi_awvalid, s0_axi_awvalid};
  assign rd_req = {s1_axi_arvalid, s0_axi_arvalid};

  axil_arb_rr u_rr (
    .req       (wr_req | rd_req),
    .last_gnt  (last_gnt),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // Grant is registered, so nothing reaches m_axi until the cycle after the request.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      owner    <= 1'b0;
      last_gnt <= 1'b1;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      ar_done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_valid) begin
            owner    <= gnt_idx;
            last_gnt <= gnt_idx;
            state    <= wr_req[gnt_idx] ? WR : RD;
          end
        end
        WR: begin
          if (m_axi_awvalid && m_axi_awready) aw_done <= 1'b1;
          if (m_axi_wvalid && m_axi_wready)   w_done  <= 1'b1;
          if (m_axi_bvalid && m_axi_bready) begin
            state   <= IDLE;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end
        end
        RD: begin
          if (m_axi_arvalid && m_axi_arready) ar_done <= 1'b1;
          if (m_axi_rvalid && m_axi_rready) begin
            state   <= IDLE;
            ar_done <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_wr = (state == WR);
  assign in_rd = (state == RD);
  assign own0  = (owner == 1'b0);
  assign own1  = (owner == 1'b1);

  assign sel_awvalid = owner ? s1_axi_awvalid : s0_axi_awvalid;
  assign sel_wvalid  = owner ? s1_axi_wvalid  : s0_axi_wvalid;
  assign sel_bready  = owner ? s1_axi_bready  : s0_axi_bready;
  assign sel_arvalid = owner ? s1_axi_arvalid : s0_axi_arvalid;
  assign sel_rready  = owner ? s1_axi_rready  : s0_axi_rready;

  assign m_axi_awvalid = in_wr && sel_awvalid && !aw_done;
  assign m_axi_wvalid  = in_wr && sel_wvalid && !w_done;
  assign m_axi_bready  = in_wr && sel_bready;
  assign m_axi_arvalid = in_rd && sel_arvalid && !ar_done;
  assign m_axi_rready  = in_rd && sel_rready;

  assign m_axi_awaddr = owner ? s1_axi_awaddr : s0_axi_awaddr;
  assign m_axi_awprot = owner ? s1_axi_awprot : s0_axi_awprot;
  assign m_axi_wdata  = owner ? s1_axi_wdata  : s0_axi_wdata;
  assign m_axi_wstrb  = owner ? s1_axi_wstrb  : s0_axi_wstrb;
  assign m_axi_araddr = owner ? s1_axi_araddr : s0_axi_araddr;
  assign m_axi_arprot = owner ? s1_axi_arprot : s0_axi_arprot;

  // Readies are masked after their handshake so a requester never sees a second accept.
  assign s0_axi_awready = in_wr && own0 && !aw_done && m_axi_awready;
  assign s0_axi_wready  = in_wr && own0 && !w_done && m_axi_wready;
  assign s0_axi_bvalid  = in_wr && own0 && m_axi_bvalid;
  assign s0_axi_arready = in_rd && own0 && !ar_done && m_axi_arready;
  assign s0_axi_rvalid  = in_rd && own0 && m_axi_rvalid;
  assign s0_axi_rdata   = m_axi_rdata;

  assign s1_axi_awready = in_wr && own1 && !aw_done && m_axi_awready;
  assign s1_axi_wready  = in_wr && own1 && !w_done && m_axi_wready;
  assign s1_axi_bvalid  = in_wr && own1 && m_axi_bvalid;
  assign s1_axi_arready = in_rd && own1 && !ar_done && m_axi_arready;
  assign s1_axi_rvalid  = in_rd && own1 && m_axi_rvalid;
  assign s1_axi_rdata   = m_axi_rdata;

endmodule

// File: tb/tb_axil_arb2.sv
// Directed bench for axil_arb2: requester and slave models driven once per clock from tasks.
`timescale 1ns/1ps
module tb_axil_arb2;
  import axil_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic s0_axi_awvalid, s0_axi_awready, s0_axi_wvalid, s0_axi_wready, s0_axi_bvalid, s0_axi_bready;
  logic s0_axi_arvalid, s0_axi_arready, s0_axi_rvalid, s0_axi_rready;
  logic [AW-1:0] s0_axi_awaddr, s0_axi_araddr;
  logic [2:0] s0_axi_awprot, s0_axi_arprot;
  logic [DW-1:0] s0_axi_wdata, s0_axi_rdata;
  logic [DW/8-1:0] s0_axi_wstrb;
  logic s1_axi_awvalid, s1_axi_awready, s1_axi_wvalid, s1_axi_wready, s1_axi_bvalid, s1_axi_bready;
  logic s1_axi_arvalid, s1_axi_arready, s1_axi_rvalid, s1_axi_rready;
  logic [AW-1:0] s1_axi_awaddr, s1_axi_araddr;
  logic [2:0] s1_axi_awprot, s1_axi_arprot;
  logic [DW-1:0] s1_axi_wdata, s1_axi_rdata;
  logic [DW/8-1:0] s1_axi_wstrb;
  logic m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready, m_axi_bvalid, m_axi_bready;
  logic m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rready;
  logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
  logic [2:0] m_axi_awprot, m_axi_arprot;
  logic [DW-1:0] m_axi_wdata, m_axi_rdata;
  logic [DW/8-1:0] m_axi_wstrb;

  axil_arb2 #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .resetn(resetn),
    .s0_axi_awvalid(s0_axi_awvalid), .s0_axi_awready(s0_axi_awready), .s0_axi_awaddr(s0_axi_awaddr),
    .s0_axi_awprot(s0_axi_awprot), .s0_axi_wvalid(s0_axi_wvalid), .s0_axi_wready(s0_axi_wready),
    .s0_axi_wdata(s0_axi_wdata), .s0_axi_wstrb(s0_axi_wstrb), .s0_axi_bvalid(s0_axi_bvalid),
    .s0_axi_bready(s0_axi_bready), .s0_axi_arvalid(s0_axi_arvalid), .s0_axi_arready(s0_axi_arready),
    .s0_axi_araddr(s0_axi_araddr), .s0_axi_arprot(s0_axi_arprot), .s0_axi_rvalid(s0_axi_rvalid),
    .s0_axi_rready(s0_axi_rready), .s0_axi_rdata(s0_axi_rdata),
    .s1_axi_awvalid(s1_axi_awvalid), .s1_axi_awready(s1_axi_awready), .s1_axi_awaddr(s1_axi_awaddr),
    .s1_axi_awprot(s1_axi_awprot), .s1_axi_wvalid(s1_axi_wvalid), .s1_axi_wready(s1_axi_wready),
    .s1_axi_wdata(s1_axi_wdata), .s1_axi_wstrb(s1_axi_wstrb), .s1_axi_bvalid(s1_axi_bvalid),
    .s1_axi_bready(s1_axi_bready), .s1_axi_arvalid(s1_axi_arvalid), .s1_axi_arready(s1_axi_arready),
    .s1_axi_araddr(s1_axi_araddr), .s1_axi_arprot(s1_axi_arprot), .s1_axi_rvalid(s1_axi_rvalid),
    .s1_axi_rready(s1_axi_rready), .s1_axi_rdata(s1_axi_rdata),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready), .m_axi_awaddr(m_axi_awaddr),
    .m_axi_awprot(m_axi_awprot), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready), .m_axi_rdata(m_axi_rdata)
  );

  int n_tests, n_fail, cyc;

  // requester models
  logic [1:0] r_aw, r_w, r_ar, wr_busy, rd_busy;
  int wr_jobs[2], rd_jobs[2];
  logic [31:0] wr_addr[2], wr_data[2], rd_addr[2];

  // slave model
  logic sl_got_aw, sl_got_w, sl_got_ar, sl_w_block;
  int sl_aw_wait, aw_delay;
  logic [31:0] sl_rdata;

  // observation log
  int ev_n, st_n, n_maw, n_mw, maw_tick;
  int ev_src[16], ev_tick[16], st_tick[16];
  logic ev_wr[16];
  logic [31:0] ev_data[16];
  logic mv_q, s1_seen, smp_any, smp_awv, smp_wv;
  logic [31:0] smp_awaddr, smp_wdata, last_maw_addr, last_mar_addr;
  logic [2:0] smp_awprot, last_mar_prot;
  logic [3:0] smp_wstrb;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic any_vr();
    return s0_axi_awready | s0_axi_wready | s0_axi_bvalid | s0_axi_arready | s0_axi_rvalid |
           s1_axi_awready | s1_axi_wready | s1_axi_bvalid | s1_axi_arready | s1_axi_rvalid |
           m_axi_awvalid | m_axi_wvalid | m_axi_bready | m_axi_arvalid | m_axi_rready;
  endfunction

  task automatic drive();
    s0_axi_awvalid = r_aw[0]; s0_axi_awaddr = wr_addr[0]; s0_axi_awprot = 3'b010;
    s0_axi_wvalid = r_w[0]; s0_axi_wdata = wr_data[0]; s0_axi_wstrb = 4'hF; s0_axi_bready = 1'b1;
    s0_axi_arvalid = r_ar[0]; s0_axi_araddr = rd_addr[0]; s0_axi_arprot = 3'b011; s0_axi_rready = 1'b1;
    s1_axi_awvalid = r_aw[1]; s1_axi_awaddr = wr_addr[1]; s1_axi_awprot = 3'b001;
    s1_axi_wvalid = r_w[1]; s1_axi_wdata = wr_data[1]; s1_axi_wstrb = 4'h3; s1_axi_bready = 1'b1;
    s1_axi_arvalid = r_ar[1]; s1_axi_araddr = rd_addr[1]; s1_axi_arprot = 3'b100; s1_axi_rready = 1'b1;
    m_axi_awready = !sl_got_aw && (sl_aw_wait >= aw_delay);
    m_axi_wready = !sl_got_w && !sl_w_block;
    m_axi_bvalid = sl_got_aw && sl_got_w;
    m_axi_arready = !sl_got_ar;
    m_axi_rvalid = sl_got_ar;
    m_axi_rdata = sl_rdata;
  endtask

  task automatic start_jobs();
    for (int n = 0; n < 2; n++) begin
      if (!wr_busy[n] && wr_jobs[n] > 0) begin
        wr_busy[n] = 1'b1; r_aw[n] = 1'b1; r_w[n] = 1'b1; wr_jobs[n]--;
      end
      if (!rd_busy[n] && rd_jobs[n] > 0) begin
        rd_busy[n] = 1'b1; r_ar[n] = 1'b1; rd_jobs[n]--;
      end
    end
  endtask

  task automatic log_event(input int n, input logic wr, input logic [31:0] d);
    if (ev_n < 16) begin
      ev_src[ev_n] = n; ev_wr[ev_n] = wr; ev_data[ev_n] = d; ev_tick[ev_n] = cyc;
    end
    ev_n++;
  endtask

  // Sample at the falling edge (inputs are stable until the next rising edge), then update models.
  task automatic tick();
    logic [1:0] h_saw, h_sw, h_sb, h_sar, h_sr;
    logic h_maw, h_mw, h_mb, h_mar, h_mr, mawv_s, mv;
    logic [31:0] rd0, rd1;
    @(negedge clk);
    h_maw = m_axi_awvalid & m_axi_awready;
    h_mw  = m_axi_wvalid & m_axi_wready;
    h_mb  = m_axi_bvalid & m_axi_bready;
    h_mar = m_axi_arvalid & m_axi_arready;
    h_mr  = m_axi_rvalid & m_axi_rready;
    h_saw = {s1_axi_awvalid & s1_axi_awready, s0_axi_awvalid & s0_axi_awready};
    h_sw  = {s1_axi_wvalid & s1_axi_wready, s0_axi_wvalid & s0_axi_wready};
    h_sb  = {s1_axi_bvalid & s1_axi_bready, s0_axi_bvalid & s0_axi_bready};
    h_sar = {s1_axi_arvalid & s1_axi_arready, s0_axi_arvalid & s0_axi_arready};
    h_sr  = {s1_axi_rvalid & s1_axi_rready, s0_axi_rvalid & s0_axi_rready};
    mawv_s = m_axi_awvalid;
    smp_awv = m_axi_awvalid; smp_wv = m_axi_wvalid; smp_awaddr = m_axi_awaddr;
    smp_awprot = m_axi_awprot; smp_wdata = m_axi_wdata; smp_wstrb = m_axi_wstrb;
    smp_any = any_vr();
    mv = m_axi_awvalid | m_axi_wvalid | m_axi_arvalid;
    if (mv && !mv_q) begin
      if (st_n < 16) st_tick[st_n] = cyc;
      st_n++;
    end
    mv_q = mv;
    if (s1_axi_rvalid | s1_axi_bvalid) s1_seen = 1'b1;
    rd0 = s0_axi_rdata; rd1 = s1_axi_rdata;
    if (h_maw) begin n_maw++; maw_tick = cyc; last_maw_addr = m_axi_awaddr; end
    if (h_mw) n_mw++;
    if (h_mar) begin last_mar_addr = m_axi_araddr; last_mar_prot = m_axi_arprot; end
    for (int n = 0; n < 2; n++) begin
      if (h_sb[n]) log_event(n, 1'b1, 32'h0);
      if (h_sr[n]) log_event(n, 1'b0, (n == 1) ? rd1 : rd0);
    end
    @(posedge clk);
    #1;
    if (h_maw) begin sl_got_aw = 1'b1; sl_aw_wait = 0; end
    else if (mawv_s && !sl_got_aw) sl_aw_wait++;
    if (h_mw) sl_got_w = 1'b1;
    if (h_mb) begin sl_got_aw = 1'b0; sl_got_w = 1'b0; end
    if (h_mar) sl_got_ar = 1'b1;
    if (h_mr) sl_got_ar = 1'b0;
    for (int n = 0; n < 2; n++) begin
      if (h_saw[n]) r_aw[n] = 1'b0;
      if (h_sw[n]) r_w[n] = 1'b0;
      if (h_sar[n]) r_ar[n] = 1'b0;
      if (h_sb[n]) wr_busy[n] = 1'b0;
      if (h_sr[n]) rd_busy[n] = 1'b0;
    end
    start_jobs();
    drive();
    cyc++;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    r_aw = '0; r_w = '0; r_ar = '0; wr_busy = '0; rd_busy = '0;
    for (int n = 0; n < 2; n++) begin
      wr_jobs[n] = 0; rd_jobs[n] = 0; wr_addr[n] = '0; wr_data[n] = '0; rd_addr[n] = '0;
    end
    sl_got_aw = 1'b0; sl_got_w = 1'b0; sl_got_ar = 1'b0; sl_w_block = 1'b0;
    sl_aw_wait = 0; aw_delay = 0; sl_rdata = '0;
    ev_n = 0; st_n = 0; n_maw = 0; n_mw = 0; maw_tick = -1; mv_q = 1'b0; s1_seen = 1'b0;
    last_maw_addr = '0; last_mar_addr = '0; last_mar_prot = '0;
    for (int i = 0; i < 16; i++) begin
      ev_src[i] = -1; ev_tick[i] = -100; st_tick[i] = -100; ev_wr[i] = 1'bx; ev_data[i] = 'x;
    end
    drive();
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  task automatic run_until(input int target, input int budget, input string tag);
    int k;
    k = 0;
    while (ev_n < target && k < budget) begin
      tick();
      k++;
    end
    chk({tag, "_events"}, ev_n, target);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    n_tests = 0; n_fail = 0; cyc = 0;
    do_reset();
    tick();
    chk("reset_outputs", 32'(smp_any), 0);

    // lone write from s0
    wr_jobs[0] = 1; wr_addr[0] = 32'h10; wr_data[0] = 32'hA5A5A5A5;
    start_jobs(); drive();
    tick();
    chk("idle_no_pass", 32'(smp_awv), 0);
    tick();
    chk("aw_valid", 32'(smp_awv), 1);
    chk("aw_addr", smp_awaddr, 32'h10);
    chk("aw_prot", 32'(smp_awprot), 32'h2);
    chk("w_valid", 32'(smp_wv), 1);
    chk("w_data", smp_wdata, 32'hA5A5A5A5);
    chk("w_strb", 32'(smp_wstrb), 32'hF);
    run_until(1, 20, "single");
    chk("single_src", ev_src[0], 0);
    chk("single_wr", 32'(ev_wr[0]), 1);
    tick();
    chk("single_idle_after", 32'(smp_any), 0);

    // simultaneous writes after reset
    do_reset();
    wr_jobs[0] = 1; wr_jobs[1] = 1; wr_addr[0] = 32'h20; wr_addr[1] = 32'h30;
    start_jobs(); drive();
    run_until(2, 40, "tie");
    chk("tie_first", ev_src[0], 0);
    chk("tie_second", ev_src[1], 1);
    chk("tie_gap", st_tick[1] - ev_tick[0], 2);
    chk("tie_addr2", last_maw_addr, 32'h30);

    // s1 keeps reading while s0 issues three writes
    do_reset();
    wr_jobs[0] = 3; rd_jobs[1] = 2; sl_rdata = 32'hCAFE0001;
    start_jobs(); drive();
    run_until(5, 120, "rr");
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("rr_src%0d", i), ev_src[i], i % 2);
      chk($sformatf("rr_wr%0d", i), 32'(ev_wr[i]), (i % 2 == 0) ? 1 : 0);
    end
    chk("rr_rdata", ev_data[1], 32'hCAFE0001);

    // s0 write and read in the same cycle
    do_reset();
    wr_jobs[0] = 1; rd_jobs[0] = 1; wr_addr[0] = 32'h44; rd_addr[0] = 32'h80; sl_rdata = 32'h12345678;
    start_jobs(); drive();
    run_until(2, 40, "wr_rd");
    chk("wr_rd_first_wr", 32'(ev_wr[0]), 1);
    chk("wr_rd_first_src", ev_src[0], 0);
    chk("wr_rd_second_rd", 32'(ev_wr[1]), 0);
    chk("wr_rd_second_src", ev_src[1], 0);
    chk("wr_rd_rdata", ev_data[1], 32'h12345678);
    chk("wr_rd_araddr", last_mar_addr, 32'h80);
    chk("wr_rd_arprot", 32'(last_mar_prot), 32'h3);
    chk("wr_rd_s1_quiet", 32'(s1_seen), 0);
    chk("wr_rd_gap", st_tick[1] - ev_tick[0], 2);

    // slave holds off awready for three cycles
    do_reset();
    aw_delay = 3; wr_jobs[0] = 1; wr_addr[0] = 32'h50; wr_data[0] = 32'h0BADF00D;
    start_jobs(); drive();
    run_until(1, 40, "aw_slow");
    chk("aw_slow_aw_count", n_maw, 1);
    chk("aw_slow_w_count", n_mw, 1);
    chk("aw_slow_delay", maw_tick - st_tick[0], 3);
    chk("aw_slow_src", ev_src[0], 0);

    // reset mid-write, after AW but before W
    do_reset();
    sl_w_block = 1'b1; wr_jobs[0] = 1; wr_addr[0] = 32'h60;
    start_jobs(); drive();
    k = 0;
    while (n_maw == 0 && k < 20) begin
      tick();
      k++;
    end
    chk("rst_aw_accepted", n_maw, 1);
    chk("rst_busy_before", 32'(any_vr()), 1);
    resetn = 1'b0;
    #1;
    chk("rst_outputs_zero", 32'(any_vr()), 0);
    do_reset();
    chk("rst_state_idle", 32'(dut.state), 32'(IDLE));
    chk("rst_last_gnt", 32'(dut.last_gnt), 1);
    wr_jobs[0] = 1; wr_jobs[1] = 1; wr_addr[0] = 32'h70; wr_addr[1] = 32'h74;
    start_jobs(); drive();
    run_until(2, 40, "rst_after");
    chk("rst_after_first", ev_src[0], 0);
    chk("rst_after_second", ev_src[1], 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
